// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan controller and its upstream mux.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam int DATA_W_DEF = 16;
  localparam int SEL_W_DEF  = 3;
  localparam int NUM_CH_DEF = 8;

  localparam logic [15:0] CONST_CH7 = 16'd42;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan controller (slave) and its requester/mux side (master).
// Optional min tracking signals exist only when MUX_SCAN_MIN_EN is defined.
interface mux_scan_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3,
  parameter int NUM_CH = 8
);
  localparam int ACC_W = DATA_W + SEL_W;

  logic              start;
  logic [NUM_CH-1:0] mask;
  logic [SEL_W-1:0]  select;
  logic [DATA_W-1:0] q_in;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] max_val;
  logic [SEL_W-1:0]  max_idx;
  logic              hit;
`ifdef MUX_SCAN_MIN_EN
  logic [DATA_W-1:0] min_val;
  logic [SEL_W-1:0]  min_idx;
`endif

  modport master (
    output start, mask, q_in,
    input  select, busy, done, sum, max_val, max_idx, hit
`ifdef MUX_SCAN_MIN_EN
    , min_val, min_idx
`endif
  );

  modport slave (
    input  start, mask, q_in,
    output select, busy, done, sum, max_val, max_idx, hit
`ifdef MUX_SCAN_MIN_EN
    , min_val, min_idx
`endif
  );

endinterface

// File: rtl/always_mux.sv
// 7+1-way data mux: select 0..6 picks a..g, select 7 returns the constant 42.
module always_mux
  import mux_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [2:0]        select,
  output logic [DATA_W-1:0] q
);

  // Channel decode
  always_comb begin
    q = '0;
    case (select)
      3'd0:    q = a;
      3'd1:    q = b;
      3'd2:    q = c;
      3'd3:    q = d;
      3'd4:    q = e;
      3'd5:    q = f;
      3'd6:    q = g;
      3'd7:    q = DATA_W'(CONST_CH7);
      default: q = '0;
    endcase
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: walks mux select over all channels, reducing enabled ones to
// sum / max (and min when MUX_SCAN_MIN_EN is defined), then pulses done.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  localparam int ACC_W = DATA_W + SEL_W;

  scan_state_e       r_state, w_state_nx;
  logic [NUM_CH-1:0] r_mask, w_mask_nx;
  logic [SEL_W-1:0]  r_idx, w_idx_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;
  logic              r_hit, w_hit_nx;
  logic [ACC_W-1:0]  r_sum, w_sum_nx;
  logic [DATA_W-1:0] r_max, w_max_nx;
  logic [SEL_W-1:0]  r_max_idx, w_max_idx_nx;
`ifdef MUX_SCAN_MIN_EN
  logic [DATA_W-1:0] r_min, w_min_nx;
  logic [SEL_W-1:0]  r_min_idx, w_min_idx_nx;
`endif

  logic w_begin;
  logic w_last;
  logic w_take;

  assign w_begin = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last  = (r_idx == SEL_W'(NUM_CH - 1));
  assign w_take  = r_mask[r_idx];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_nx = SCAN;
        else           w_state_nx = IDLE;
      end
      SCAN: begin
        if (w_last) w_state_nx = DONE;
        else        w_state_nx = SCAN;
      end
      DONE: begin
        if (bus.start) w_state_nx = SCAN;
        else           w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Index counter and reduction datapath next values
  always_comb begin
    w_mask_nx    = r_mask;
    w_idx_nx     = r_idx;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_hit_nx     = r_hit;
    w_sum_nx     = r_sum;
    w_max_nx     = r_max;
    w_max_idx_nx = r_max_idx;
`ifdef MUX_SCAN_MIN_EN
    w_min_nx     = r_min;
    w_min_idx_nx = r_min_idx;
`endif
    if (w_begin) begin
      w_mask_nx    = bus.mask;
      w_idx_nx     = '0;
      w_busy_nx    = 1'b1;
      w_hit_nx     = 1'b0;
      w_sum_nx     = '0;
      w_max_nx     = '0;
      w_max_idx_nx = '0;
`ifdef MUX_SCAN_MIN_EN
      w_min_nx     = '0;
      w_min_idx_nx = '0;
`endif
    end else if (r_state == SCAN) begin
      if (w_take) begin
        w_sum_nx = r_sum + ACC_W'(bus.q_in);
        // Strict compares: an equal later value never displaces the earlier index
        if (!r_hit || (bus.q_in > r_max)) begin
          w_max_nx     = bus.q_in;
          w_max_idx_nx = r_idx;
        end else begin
          w_max_nx     = r_max;
        end
`ifdef MUX_SCAN_MIN_EN
        if (!r_hit || (bus.q_in < r_min)) begin
          w_min_nx     = bus.q_in;
          w_min_idx_nx = r_idx;
        end else begin
          w_min_nx     = r_min;
        end
`endif
        w_hit_nx = 1'b1;
      end else begin
        w_sum_nx = r_sum;
      end
      if (w_last) begin
        w_idx_nx  = '0;
        w_busy_nx = 1'b0;
        w_done_nx = 1'b1;
      end else begin
        w_idx_nx  = r_idx + SEL_W'(1);
      end
    end else begin
      w_idx_nx  = '0;
      w_busy_nx = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hit     <= 1'b0;
      r_sum     <= '0;
      r_max     <= '0;
      r_max_idx <= '0;
`ifdef MUX_SCAN_MIN_EN
      r_min     <= '0;
      r_min_idx <= '0;
`endif
    end else begin
      r_mask    <= w_mask_nx;
      r_idx     <= w_idx_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_hit     <= w_hit_nx;
      r_sum     <= w_sum_nx;
      r_max     <= w_max_nx;
      r_max_idx <= w_max_idx_nx;
`ifdef MUX_SCAN_MIN_EN
      r_min     <= w_min_nx;
      r_min_idx <= w_min_idx_nx;
`endif
    end
  end

  assign bus.select  = r_idx;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sum     = r_sum;
  assign bus.max_val = r_max;
  assign bus.max_idx = r_max_idx;
  assign bus.hit     = r_hit;
`ifdef MUX_SCAN_MIN_EN
  assign bus.min_val = r_min;
  assign bus.min_idx = r_min_idx;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl driving always_mux; scoreboard of
// expected scan results from a reference model. Honors MUX_SCAN_MIN_EN.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int DATA_W = DATA_W_DEF;
  localparam int SEL_W  = SEL_W_DEF;
  localparam int NUM_CH = NUM_CH_DEF;
  localparam int ACC_W  = DATA_W + SEL_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] ch [NUM_CH];
  logic [DATA_W-1:0] w_q;

  mux_scan_ctrl_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_CH(NUM_CH)) bus ();

  always_mux #(.DATA_W(DATA_W)) u_mux (
    .a(ch[0]), .b(ch[1]), .c(ch[2]), .d(ch[3]),
    .e(ch[4]), .f(ch[5]), .g(ch[6]),
    .select(bus.select), .q(w_q)
  );
  assign bus.q_in = w_q;

  mux_scan_ctrl #(.DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] max_val;
    logic [SEL_W-1:0]  max_idx;
    logic              hit;
    logic [DATA_W-1:0] min_val;
    logic [SEL_W-1:0]  min_idx;
  } exp_t;

  typedef struct {
    int                sel_err;
    int                busy_err;
    int                done_early;
    logic              done_end;
    logic              busy_end;
    logic [SEL_W-1:0]  sel_end;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] max_val;
    logic [SEL_W-1:0]  max_idx;
    logic              hit;
    logic [DATA_W-1:0] min_val;
    logic [SEL_W-1:0]  min_idx;
    logic              done_after;
    logic [ACC_W-1:0]  sum_after;
  } obs_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic exp_t model(input logic [NUM_CH-1:0] m);
    exp_t r;
    logic [DATA_W-1:0] v;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      v = (i == 7) ? CONST_CH7 : ch[i];
      if (m[i]) begin
        r.sum = r.sum + ACC_W'(v);
        if (!r.hit || v > r.max_val) begin r.max_val = v; r.max_idx = SEL_W'(i); end
        if (!r.hit || v < r.min_val) begin r.min_val = v; r.min_idx = SEL_W'(i); end
        r.hit = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic set_inputs(input int base);
    for (int i = 0; i < 7; i++) ch[i] = DATA_W'(base + i);
    ch[7] = '0;
  endtask

  // Drive one scan and record what the DUT does; comparisons are in the tests.
  task automatic do_scan(input logic [NUM_CH-1:0] m, output obs_t o);
    o.sel_err = 0; o.busy_err = 0; o.done_early = 0;
    @(negedge clk);
    bus.mask  = m;
    bus.start = 1'b1;
    sb.push_back(model(m));
    @(negedge clk);
    bus.start = 1'b0;
    bus.mask  = ~m;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.select !== SEL_W'(c)) o.sel_err++;
      if (bus.busy !== 1'b1)        o.busy_err++;
      if (bus.done !== 1'b0)        o.done_early++;
      @(negedge clk);
    end
    o.done_end = bus.done;
    o.busy_end = bus.busy;
    o.sel_end  = bus.select;
    o.sum      = bus.sum;
    o.max_val  = bus.max_val;
    o.max_idx  = bus.max_idx;
    o.hit      = bus.hit;
`ifdef MUX_SCAN_MIN_EN
    o.min_val  = bus.min_val;
    o.min_idx  = bus.min_idx;
`else
    o.min_val  = '0;
    o.min_idx  = '0;
`endif
    @(negedge clk);
    o.done_after = bus.done;
    o.sum_after  = bus.sum;
  endtask

  task automatic test_reset();
    logic [ACC_W+DATA_W+2*SEL_W+2:0] all_out;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.mask  = '0;
    set_inputs(1);
    repeat (2) @(negedge clk);
    all_out = {bus.select, bus.busy, bus.done, bus.sum, bus.max_val, bus.max_idx, bus.hit};
    vectors++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", all_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_scan();
    obs_t o;
    exp_t e;
    set_inputs(1);
    do_scan(8'hFF, o);
    vectors++; if (o.sel_err !== 0) begin errors++; $display("FAIL select_walk: %0d wrong cycles, want 0", o.sel_err); end
    vectors++; if (o.busy_err !== 0) begin errors++; $display("FAIL busy_window: %0d wrong cycles, want 0", o.busy_err); end
    vectors++; if (o.done_early !== 0) begin errors++; $display("FAIL done_early: %0d cycles, want 0", o.done_early); end
    vectors++; if ({o.done_end, o.busy_end, o.sel_end} !== {1'b1, 1'b0, SEL_W'(0)}) begin
      errors++; $display("FAIL done_cycle: done=%b busy=%b sel=%0d, want 1 0 0", o.done_end, o.busy_end, o.sel_end);
    end
    vectors++; if (o.done_after !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b, want 0", o.done_after); end
    vectors++; if (o.sum_after !== o.sum) begin errors++; $display("FAIL result_hold: got %0d, want %0d", o.sum_after, o.sum); end
    if (o.done_end === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      vectors++; if (o.sum !== e.sum) begin errors++; $display("FAIL full_sum: got %0d, want %0d", o.sum, e.sum); end
      vectors++; if ({o.max_val, o.max_idx, o.hit} !== {e.max_val, e.max_idx, e.hit}) begin
        errors++; $display("FAIL full_max: got %0d@%0d hit=%b, want %0d@%0d hit=%b",
                           o.max_val, o.max_idx, o.hit, e.max_val, e.max_idx, e.hit);
      end
    end else begin
      sb.delete();
      vectors++; errors++; $display("FAIL full_no_done: got done=%b, want 1", o.done_end);
    end
  endtask

  task automatic test_mask_7f();
    obs_t o;
    exp_t e;
    set_inputs(1);
    do_scan(8'h7F, o);
    if (o.done_end === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      vectors++; if ({o.sum, o.max_val, o.max_idx} !== {e.sum, e.max_val, e.max_idx}) begin
        errors++; $display("FAIL mask7f: got sum=%0d max=%0d@%0d, want sum=%0d max=%0d@%0d",
                           o.sum, o.max_val, o.max_idx, e.sum, e.max_val, e.max_idx);
      end
    end else begin
      sb.delete();
      vectors++; errors++; $display("FAIL mask7f_no_done: got done=%b, want 1", o.done_end);
    end
  endtask

  task automatic test_tie();
    obs_t o;
    exp_t e;
    for (int i = 0; i < 7; i++) ch[i] = DATA_W'(5);
    ch[0] = DATA_W'(100);
    ch[2] = DATA_W'(100);
    do_scan(8'h05, o);
    if (o.done_end === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      vectors++; if ({o.sum, o.max_val, o.max_idx, o.hit} !== {e.sum, e.max_val, e.max_idx, e.hit}) begin
        errors++; $display("FAIL tie_max: got sum=%0d max=%0d@%0d, want sum=%0d max=%0d@%0d",
                           o.sum, o.max_val, o.max_idx, e.sum, e.max_val, e.max_idx);
      end
`ifdef MUX_SCAN_MIN_EN
      vectors++; if ({o.min_val, o.min_idx} !== {e.min_val, e.min_idx}) begin
        errors++; $display("FAIL tie_min: got %0d@%0d, want %0d@%0d", o.min_val, o.min_idx, e.min_val, e.min_idx);
      end
`endif
    end else begin
      sb.delete();
      vectors++; errors++; $display("FAIL tie_no_done: got done=%b, want 1", o.done_end);
    end
    // Distinct values so min and max land on different channels
    set_inputs(10);
    do_scan(8'h3C, o);
    if (o.done_end === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      vectors++; if ({o.sum, o.max_val, o.max_idx} !== {e.sum, e.max_val, e.max_idx}) begin
        errors++; $display("FAIL mid_mask: got sum=%0d max=%0d@%0d, want sum=%0d max=%0d@%0d",
                           o.sum, o.max_val, o.max_idx, e.sum, e.max_val, e.max_idx);
      end
`ifdef MUX_SCAN_MIN_EN
      vectors++; if ({o.min_val, o.min_idx} !== {e.min_val, e.min_idx}) begin
        errors++; $display("FAIL mid_min: got %0d@%0d, want %0d@%0d", o.min_val, o.min_idx, e.min_val, e.min_idx);
      end
`endif
    end else begin
      sb.delete();
      vectors++; errors++; $display("FAIL mid_no_done: got done=%b, want 1", o.done_end);
    end
  endtask

  task automatic test_empty_mask();
    obs_t o;
    exp_t e;
    set_inputs(1);
    do_scan(8'h00, o);
    vectors++; if (o.done_end !== 1'b1) begin errors++; $display("FAIL empty_done: got %b, want 1", o.done_end); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++; if ({o.sum, o.max_val, o.max_idx, o.hit, o.min_val, o.min_idx} !==
                     {e.sum, e.max_val, e.max_idx, e.hit, e.min_val, e.min_idx}) begin
        errors++; $display("FAIL empty_results: got sum=%0d max=%0d@%0d hit=%b, want 0",
                           o.sum, o.max_val, o.max_idx, o.hit);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    obs_t o;
    exp_t e;
    int   cnt;
    int   done_seen;
    set_inputs(1);
    @(negedge clk);
    bus.mask  = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.select !== SEL_W'(3) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    vectors++; if (cnt >= 20) begin errors++; $display("FAIL abort_reach_sel3: got timeout, want select=3"); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({bus.select, bus.busy, bus.done, bus.sum, bus.max_val, bus.max_idx, bus.hit} !== '0) begin
      errors++; $display("FAIL abort_outputs: got sel=%0d busy=%b sum=%0d hit=%b, want 0",
                         bus.select, bus.busy, bus.sum, bus.hit);
    end
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_seen++;
    end
    vectors++; if (done_seen !== 0) begin errors++; $display("FAIL abort_done_pulse: got %0d, want 0", done_seen); end
    do_scan(8'hFF, o);
    if (o.done_end === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      vectors++; if ({o.sum, o.max_val, o.max_idx, o.hit} !== {e.sum, e.max_val, e.max_idx, e.hit}) begin
        errors++; $display("FAIL post_abort_scan: got sum=%0d max=%0d@%0d, want sum=%0d max=%0d@%0d",
                           o.sum, o.max_val, o.max_idx, e.sum, e.max_val, e.max_idx);
      end
    end else begin
      sb.delete();
      vectors++; errors++; $display("FAIL post_abort_no_done: got done=%b, want 1", o.done_end);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cnt;
    set_inputs(1);
    @(negedge clk);
    bus.mask  = 8'hFF;
    bus.start = 1'b1;
    sb.push_back(model(8'hFF));
    for (int s = 0; s < 3; s++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (bus.done !== 1'b1 && cnt < 20);
      vectors++; if (cnt !== NUM_CH + 1) begin
        errors++; $display("FAIL b2b_period[%0d]: got %0d cycles, want %0d", s, cnt, NUM_CH + 1);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++; if (bus.sum !== e.sum) begin
          errors++; $display("FAIL b2b_sum[%0d]: got %0d, want %0d", s, bus.sum, e.sum);
        end
      end
      if (s < 2) sb.push_back(model(8'hFF));
      else       bus.start = 1'b0;
    end
    @(negedge clk);
    vectors++; if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_scan();
    test_mask_7f();
    test_tie();
    test_empty_mask();
    test_reset_mid_scan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
